uart_rx: RTL

- 8N1 UART receiver, the receive-side counterpart of the existing UART transmitter; same baud arithmetic (clocks per bit = CLK_FREQ / BAUDRATE).
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each bit at its centre and presents the received byte on a valid/ack holding register, with framing and overrun status.

---
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, valid/ack holding register.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data and stop (8E1).
module uart_rx #(
    parameter int CLK_FREQ     = 10000000,
    parameter int BAUDRATE     = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUDRATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       sync_reg;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             deliver_reg, deliver_next;
    logic [7:0]       rx_data_reg, rx_data_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             overrun_reg, overrun_next;
    logic             parity_bad;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit_reg, parity_bit_next;
    logic             parity_err_reg, parity_err_next;
`endif

    // Line idles high, so the synchroniser resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
        end
    end

    assign rx_sync = sync_reg[1];

`ifdef UART_RX_PARITY_EN
    assign parity_bad = (^shift_reg) != parity_bit_reg;
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            deliver_reg    <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            deliver_reg    <= deliver_next;
            rx_data_reg    <= rx_data_next;
            rx_valid_reg   <= rx_valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        deliver_next    = 1'b0;
        frame_err_next  = 1'b0;
        rx_data_next    = rx_data_reg;
        rx_valid_next   = rx_valid_reg;
        overrun_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end

            // Half a bit in: a high line here means a glitch, not a frame.
            ST_START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rx_sync) begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next     = '0;
                    shift_next   = {rx_sync, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next        = '0;
                    parity_bit_next = rx_sync;
                    state_next      = ST_STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`endif

            // Leave mid-stop-bit so a start edge right after the stop bit is caught.
            ST_STOP: begin
                if (cnt_reg == CNT_FULL) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                    if (!rx_sync) begin
                        frame_err_next = 1'b1;
                    end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_next = 1'b1;
`endif
                    end else begin
                        deliver_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (rx_valid_reg && rx_ack) begin
            rx_valid_next = 1'b0;
        end

        // A new byte always wins; it only counts as overrun if the old one was never acked.
        if (deliver_reg) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            overrun_next  = rx_valid_reg && !rx_ack;
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule
